// File: rtl/debuger_sel_arbiter_if.sv
// Probe activity / selection bus between the probe connectors and the
// debugger-select arbiter.
//
//   STLINK_ACT   [1:0]  {STLINK_JTCK_RESET, STLINK_JTCK_SWCLK}, asynchronous
//   JLINK_ACT    [1:0]  {JLINK_RESET, JLINK_JTCK_SWCLK}, asynchronous
//   DAPLINK_ACT  [1:0]  {DAPLINK_RESET, DAPLINK_JTCK_SWCLK}, asynchronous
//   DEBUGER_TYPE [1:0]  11 STLINK, 10 JLINK, 01 DAPLINK, 00 none
//   TYPE_VALID          high while a probe holds ownership
//   SWITCH_PULSE        one-cycle strobe when DEBUGER_TYPE changes value
//
// master: the side that drives probe activity and consumes the selection.
// slave : the arbiter.
interface debuger_sel_arbiter_if;
    logic [1:0] STLINK_ACT;
    logic [1:0] JLINK_ACT;
    logic [1:0] DAPLINK_ACT;
    logic [1:0] DEBUGER_TYPE;
    logic       TYPE_VALID;
    logic       SWITCH_PULSE;

    modport master (
        output STLINK_ACT, JLINK_ACT, DAPLINK_ACT,
        input  DEBUGER_TYPE, TYPE_VALID, SWITCH_PULSE
    );

    modport slave (
        input  STLINK_ACT, JLINK_ACT, DAPLINK_ACT,
        output DEBUGER_TYPE, TYPE_VALID, SWITCH_PULSE
    );
endinterface

// File: rtl/debuger_sel_arbiter.sv
// Probe-activity arbiter feeding the CPLD debugger signal mux.
//
// Synchronises the RESET/SWCLK pair of each probe, qualifies activity by
// counting edges inside a gap window, locks ownership to the first probe
// that qualifies (STLINK > JLINK > DAPLINK on a tie) and releases it after
// the owner has been quiet for IDLE_CYCLES. DEBUGER_TYPE is sticky across
// release so the mux keeps routing the last owner.
//
// Ports:
//   SYS_CLK    block clock
//   SYS_RST_N  asynchronous active-low reset
//   bus        debuger_sel_arbiter_if.slave (probe ACT inputs, selection outputs)
module debuger_sel_arbiter #(
    parameter int CLAIM_EDGES = 4,
    parameter int GAP_CYCLES  = 1024,
    parameter int IDLE_CYCLES = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RST_N,
    debuger_sel_arbiter_if.slave bus
);
    localparam int NPROBE = 3;
    localparam int EC_W   = 4;
    localparam logic [EC_W-1:0]  CLAIM_MAX = EC_W'(CLAIM_EDGES);
    localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES);

    typedef enum logic {IDLE, OWN} state_t;

    state_t state, state_n;

    // Probe index 0 = STLINK, 1 = JLINK, 2 = DAPLINK (also priority order).
    logic [2*NPROBE-1:0] act_raw;
    logic [2*NPROBE-1:0] act_p0;
    logic [2*NPROBE-1:0] act_p1;
    logic [2*NPROBE-1:0] prev_p1;
    logic [NPROBE-1:0]   edge_p2;
    logic [1:0]          arm_cnt;

    logic [EC_W-1:0]  edge_cnt   [NPROBE];
    logic [EC_W-1:0]  edge_cnt_n [NPROBE];
    logic [CNT_W-1:0] gap_cnt    [NPROBE];
    logic [CNT_W-1:0] gap_cnt_n  [NPROBE];
    logic [CNT_W-1:0] idle_cnt, idle_cnt_n;
    logic [NPROBE-1:0] claim;
    logic [1:0]        win;
    logic [1:0]        owner, owner_n;
    logic [1:0]        type_q, type_n;
    logic              valid_q, valid_n;
    logic              pulse_q, pulse_n;

    function automatic logic [EC_W-1:0] sat_edge(input logic [EC_W-1:0] c);
        return (c >= CLAIM_MAX) ? CLAIM_MAX : c + EC_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c,
                                                 input logic [CNT_W-1:0] lim);
        return (c >= lim) ? lim : c + CNT_W'(1);
    endfunction

    // Probe index to mux code: 0 -> 11, 1 -> 10, 2 -> 01.
    function automatic logic [1:0] type_code(input logic [1:0] p);
        return 2'd3 - p;
    endfunction

    assign act_raw = {bus.STLINK_ACT, bus.JLINK_ACT, bus.DAPLINK_ACT};

    // Stage p0/p1: two-flop synchroniser; prev_p1 holds the last synced pair.
    // Stage p2: registered edge flag, forced low while the arming counter
    // runs so power-up levels never count as activity.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            act_p0  <= '0;
            act_p1  <= '0;
            prev_p1 <= '0;
            edge_p2 <= '0;
            arm_cnt <= '0;
        end else begin
            act_p0  <= act_raw;
            act_p1  <= act_p0;
            prev_p1 <= act_p1;
            if (arm_cnt != 2'd3) begin
                arm_cnt <= arm_cnt + 2'd1;
                edge_p2 <= '0;
            end else begin
                for (int p = 0; p < NPROBE; p++) begin
                    edge_p2[p] <= |(act_p1[(NPROBE-1-p)*2 +: 2] ^
                                    prev_p1[(NPROBE-1-p)*2 +: 2]);
                end
            end
        end
    end

    // Qualifier and ownership next-state
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        type_n     = type_q;
        valid_n    = valid_q;
        pulse_n    = 1'b0;
        idle_cnt_n = idle_cnt;
        win        = 2'd0;
        for (int p = 0; p < NPROBE; p++) begin
            gap_cnt_n[p]  = edge_p2[p] ? '0 : sat_cnt(gap_cnt[p], GAP_MAX);
            edge_cnt_n[p] = edge_cnt[p];
            claim[p]      = (edge_cnt[p] == CLAIM_MAX);
        end

        case (state)
            IDLE: begin
                idle_cnt_n = '0;
                if (|claim) begin
                    win     = claim[0] ? 2'd0 : (claim[1] ? 2'd1 : 2'd2);
                    state_n = OWN;
                    owner_n = win;
                    type_n  = type_code(win);
                    valid_n = 1'b1;
                    // Re-selecting the sticky type is not a switch.
                    pulse_n = (type_code(win) != type_q);
                    for (int p = 0; p < NPROBE; p++) edge_cnt_n[p] = '0;
                end else begin
                    for (int p = 0; p < NPROBE; p++) begin
                        // An edge landing on the gap timeout starts a new burst.
                        if (edge_p2[p])
                            edge_cnt_n[p] = (gap_cnt[p] == GAP_MAX) ? EC_W'(1)
                                                                    : sat_edge(edge_cnt[p]);
                        else if (gap_cnt[p] == GAP_MAX)
                            edge_cnt_n[p] = '0;
                    end
                end
            end
            OWN: begin
                // Nobody can build up a claim while ownership is locked, so a
                // claim cannot coincide with release either.
                for (int p = 0; p < NPROBE; p++) edge_cnt_n[p] = '0;
                if (edge_p2[owner])
                    idle_cnt_n = '0;
                else if (idle_cnt == IDLE_MAX) begin
                    state_n    = IDLE;
                    valid_n    = 1'b0;
                    idle_cnt_n = '0;
                end else
                    idle_cnt_n = idle_cnt + CNT_W'(1);
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state    <= IDLE;
            owner    <= '0;
            type_q   <= '0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
            idle_cnt <= '0;
            for (int p = 0; p < NPROBE; p++) begin
                edge_cnt[p] <= '0;
                gap_cnt[p]  <= '0;
            end
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            type_q   <= type_n;
            valid_q  <= valid_n;
            pulse_q  <= pulse_n;
            idle_cnt <= idle_cnt_n;
            for (int p = 0; p < NPROBE; p++) begin
                edge_cnt[p] <= edge_cnt_n[p];
                gap_cnt[p]  <= gap_cnt_n[p];
            end
        end
    end

    assign bus.DEBUGER_TYPE = type_q;
    assign bus.TYPE_VALID   = valid_q;
    assign bus.SWITCH_PULSE = pulse_q;

endmodule

// File: tb/tb_debuger_sel_arbiter.sv
// Bench for debuger_sel_arbiter with shortened gap/idle windows.
// A time-difference reference model (sample history + last-edge times per
// probe) predicts the outputs after every clock edge; directed steps add
// checks on latency, priority, stickiness and boundary behaviour.
module tb_debuger_sel_arbiter;
    localparam int CLAIM = 4;
    localparam int GAP   = 40;
    localparam int IDLE  = 300;
    localparam int CW    = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] st_act, jl_act, dp_act;

    always #5 clk = ~clk;

    debuger_sel_arbiter_if bus_if ();
    assign bus_if.STLINK_ACT  = st_act;
    assign bus_if.JLINK_ACT   = jl_act;
    assign bus_if.DAPLINK_ACT = dp_act;

    debuger_sel_arbiter #(
        .CLAIM_EDGES (CLAIM),
        .GAP_CYCLES  (GAP),
        .IDLE_CYCLES (IDLE),
        .CNT_W       (CW)
    ) dut (
        .SYS_CLK   (clk),
        .SYS_RST_N (rst_n),
        .bus       (bus_if.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int pulse_seen = 0;
    int cyc_total  = 0;

    // Reference model state
    logic [5:0] samp [$];
    int   m_cyc;
    int   cnt  [3];
    int   last [3];
    bit   m_own;
    int   m_owner;
    int   idle_ref;
    logic [1:0] m_type;
    bit   m_valid, m_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        samp.push_back(6'd0);
        m_cyc = 0;
        for (int p = 0; p < 3; p++) begin cnt[p] = 0; last[p] = 0; end
        m_own = 0; m_owner = 0; idle_ref = 0;
        m_type = 2'b00; m_valid = 0; m_pulse = 0;
    endtask

    // Edge m (counted from reset release) sees the input sampled at edge m-3
    // compared with the one sampled at m-4; counts become visible on edge m.
    task automatic model_step();
        bit e [3];
        logic [5:0] a, b;
        int win;
        logic [1:0] code;
        m_cyc++;
        samp.push_back({st_act, jl_act, dp_act});
        for (int p = 0; p < 3; p++) begin
            e[p] = 0;
            if (m_cyc >= 5) begin
                a = samp[m_cyc-3];
                b = samp[m_cyc-4];
                e[p] = (a[(2-p)*2 +: 2] != b[(2-p)*2 +: 2]);
            end
        end
        m_pulse = 0;
        if (!m_own) begin
            win = -1;
            for (int p = 0; p < 3; p++) if (win < 0 && cnt[p] == CLAIM) win = p;
            if (win >= 0) begin
                code = 2'(3 - win);
                m_own = 1; m_owner = win; m_valid = 1;
                m_pulse = (m_type != code);
                m_type = code;
                idle_ref = m_cyc;
                for (int p = 0; p < 3; p++) cnt[p] = 0;
            end else begin
                for (int p = 0; p < 3; p++) begin
                    if (e[p]) cnt[p] = (m_cyc - last[p] > GAP) ? 1 : ((cnt[p] < CLAIM) ? cnt[p] + 1 : CLAIM);
                    else if (m_cyc - last[p] > GAP) cnt[p] = 0;
                end
            end
        end else begin
            if (e[m_owner]) idle_ref = m_cyc;
            else if (m_cyc - idle_ref > IDLE) begin m_own = 0; m_valid = 0; end
        end
        for (int p = 0; p < 3; p++) if (e[p]) last[p] = m_cyc;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check("per_cycle", {bus_if.DEBUGER_TYPE, bus_if.TYPE_VALID, bus_if.SWITCH_PULSE},
              {m_type, m_valid, m_pulse});
        if (bus_if.SWITCH_PULSE === 1'b1) pulse_seen++;
        cyc_total++;
    endtask

    task automatic flip(input int p, input int b);
        case (p)
            0:       st_act[b] = ~st_act[b];
            1:       jl_act[b] = ~jl_act[b];
            default: dp_act[b] = ~dp_act[b];
        endcase
    endtask

    task automatic burst(input int p, input int n, input int period);
        for (int i = 0; i < n; i++) begin
            flip(p, 0);
            repeat (period) cyc();
        end
    endtask

    task automatic wait_release(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (bus_if.TYPE_VALID === 1'b0) break;
            cyc();
        end
        check("release_timeout", bus_if.TYPE_VALID, 0);
    endtask

    initial begin
        int p0, ktog, seen, mask, rate;
        rst_n  = 1'b0;
        st_act = 2'($urandom);
        jl_act = 2'($urandom);
        dp_act = 2'($urandom);
        model_reset();
        repeat (3) cyc();
        check("reset_state", {bus_if.DEBUGER_TYPE, bus_if.TYPE_VALID, bus_if.SWITCH_PULSE}, 0);
        rst_n = 1'b1;

        // 1: static power-up levels never claim
        repeat (5000) cyc();
        check("static_type", bus_if.DEBUGER_TYPE, 2'b00);
        check("static_valid", bus_if.TYPE_VALID, 0);
        check("static_pulses", pulse_seen, 0);

        // 2: STLINK claim latency
        p0 = pulse_seen;
        for (int i = 0; i < 3; i++) begin flip(0, 0); repeat (20) cyc(); end
        flip(0, 0);
        ktog = cyc_total + 1;
        seen = -1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (bus_if.TYPE_VALID === 1'b1) begin seen = cyc_total; break; end
        end
        check("claim_latency", seen - ktog, 4);
        check("claim_type", bus_if.DEBUGER_TYPE, 2'b11);
        repeat (10) cyc();
        check("claim_pulses", pulse_seen - p0, 1);

        // 3: JLINK activity ignored while STLINK owns
        p0 = pulse_seen;
        for (int i = 0; i < 100; i++) begin
            flip(1, 0);
            if (i % 10 == 9) flip(0, 0);
            repeat (5) cyc();
        end
        check("locked_type", bus_if.DEBUGER_TYPE, 2'b11);
        check("locked_valid", bus_if.TYPE_VALID, 1);
        check("locked_pulses", pulse_seen - p0, 0);

        // 4: release keeps sticky type, then JLINK takes over
        wait_release(IDLE + 60);
        check("sticky_type", bus_if.DEBUGER_TYPE, 2'b11);
        check("release_pulses", pulse_seen - p0, 0);
        burst(1, 4, 20);
        check("jlink_type", bus_if.DEBUGER_TYPE, 2'b10);
        check("jlink_valid", bus_if.TYPE_VALID, 1);
        check("jlink_pulses", pulse_seen - p0, 1);

        // 5: simultaneous JLINK/DAPLINK, JLINK wins; re-select gives no pulse
        wait_release(IDLE + 60);
        p0 = pulse_seen;
        for (int i = 0; i < 4; i++) begin flip(1, 0); flip(2, 0); repeat (20) cyc(); end
        check("prio_type", bus_if.DEBUGER_TYPE, 2'b10);
        check("prio_valid", bus_if.TYPE_VALID, 1);
        check("reselect_pulses", pulse_seen - p0, 0);
        check("dap_edge_cnt", 32'(dut.edge_cnt[2]), cnt[2]);

        // 6: burst broken by a gap does not claim; completing it does
        wait_release(IDLE + 60);
        burst(1, 3, 20);
        repeat (GAP + 5) cyc();
        burst(1, 3, 20);
        check("gap_noclaim", bus_if.TYPE_VALID, 0);
        flip(1, 0);
        repeat (10) cyc();
        check("gap_claim_valid", bus_if.TYPE_VALID, 1);
        check("gap_claim_type", bus_if.DEBUGER_TYPE, 2'b10);

        // 7: edge spacing of GAP+1 restarts, spacing of GAP accumulates
        wait_release(IDLE + 60);
        p0 = pulse_seen;
        burst(0, 4, GAP + 1);
        check("gap_edge_noclaim", bus_if.TYPE_VALID, 0);
        burst(0, 4, GAP);
        check("gap_edge_type", bus_if.DEBUGER_TYPE, 2'b11);
        check("gap_edge_pulses", pulse_seen - p0, 1);

        // 8: asynchronous reset while owning, then re-arm with new levels
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", {bus_if.DEBUGER_TYPE, bus_if.TYPE_VALID, bus_if.SWITCH_PULSE}, 0);
        st_act = ~st_act;
        jl_act = ~jl_act;
        dp_act = 2'($urandom);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (100) cyc();
        check("rearm_valid", bus_if.TYPE_VALID, 0);
        check("rearm_type", bus_if.DEBUGER_TYPE, 2'b00);

        // 9: random activity on both bits of random probe subsets
        for (int ph = 0; ph < 10; ph++) begin
            mask = $urandom_range(0, 7);
            rate = $urandom_range(4, 60);
            for (int c = 0; c < 500; c++) begin
                for (int p = 0; p < 3; p++)
                    if (mask[p] && $urandom_range(0, rate - 1) == 0) flip(p, $urandom_range(0, 1));
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
